aes_job_arbiter: RTL

Shares a single AES-128 round-iterative core (`SubBytes` engine: `read_enable`/`done` handshake, 128-bit data and key) among `NUM_REQ` requesters. It selects one pending job by round-robin and holds the core in reset between jobs. It then sequences clear, load and wait, guards the core with a watchdog, and returns the result to the granted requester as a one-cycle response. It sits between the system-side job sources and the AES datapath, and it is the only block that drives the core's `rst` and `read_enable`.

---
 rtl/aes_pkg.sv | 17 +
 rtl/aes_job_arbiter_if.sv | 30 +++
 rtl/rr_arbiter.sv | 36 +++
 rtl/aes_job_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared definitions for the AES job arbiter slice.
// Provides the AES block width, the watchdog counter width and the
// arbiter FSM state encoding.
package aes_pkg;

  localparam int unsigned AES_BLOCK_W = 128;
  localparam int unsigned WD_W        = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_LOAD  = 3'd2,
    ST_BUSY  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/aes_job_arbiter_if.sv
// Requester-side job bus of the AES job arbiter.
// Signals:
//   req_valid/req_data/req_key : per-requester job request (128-bit slices)
//   req_ready                  : one-hot accept strobe
//   rsp_valid/rsp_data/rsp_err : one-hot one-cycle response, result, abort flag
// Modports: master = job sources, slave = arbiter.
interface aes_job_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import aes_pkg::*;

  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ*AES_BLOCK_W-1:0] req_data;
  logic [NUM_REQ*AES_BLOCK_W-1:0] req_key;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ-1:0]             rsp_valid;
  logic [AES_BLOCK_W-1:0]         rsp_data;
  logic                           rsp_err;

  modport master (
    output req_valid, req_data, req_key,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_data, req_key,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
// Ports:
//   req        : pending request vector
//   last_grant : index granted most recently (search starts one above it)
//   grant      : one-hot winner, zero when no request is pending
//   grant_idx  : binary index of the winner
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  int w_idx;

  // Walk offsets from farthest to nearest so the nearest pending
  // requester above last_grant is the final (winning) assignment.
  always_comb begin
    w_idx     = 0;
    grant_idx = '0;
    for (int off = int'(NUM_REQ); off >= 1; off--) begin
      w_idx = int'(last_grant) + off;
      if (w_idx >= int'(NUM_REQ)) begin
        w_idx = w_idx - int'(NUM_REQ);
      end
      if (req[IDX_W'(w_idx)]) begin
        grant_idx = IDX_W'(w_idx);
      end
    end
    grant = (|req) ? (NUM_REQ'(1) << grant_idx) : '0;
  end

endmodule

// File: rtl/aes_job_arbiter.sv
// Shares one round-iterative AES-128 core among NUM_REQ requesters.
// Picks a job round-robin, holds the core in reset between jobs,
// sequences clear/load/wait with a watchdog, and returns the result
// as a one-cycle one-hot response.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   job              : requester bus (slave side)
//   core_rst         : core reset, high in IDLE/CLEAR
//   core_read_enable : one-cycle load pulse in LOAD
//   core_data/key    : latched job payload to the core
//   core_out_data    : core result
//   core_done        : core completion level, honoured only in BUSY
module aes_job_arbiter
  import aes_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 63
) (
  input  logic                   clk,
  input  logic                   rst,
  aes_job_arbiter_if.slave       job,
  output logic                   core_rst,
  output logic                   core_read_enable,
  output logic [AES_BLOCK_W-1:0] core_data,
  output logic [AES_BLOCK_W-1:0] core_key,
  input  logic [AES_BLOCK_W-1:0] core_out_data,
  input  logic                   core_done
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  state_e                 r_state;
  state_e                 w_next;
  logic [IDX_W-1:0]       r_last_grant;
  logic [WD_W-1:0]        r_wd_cnt;
  logic [NUM_REQ-1:0]     r_rsp_valid;
  logic [AES_BLOCK_W-1:0] r_rsp_data;
  logic                   r_rsp_err;
  logic                   r_core_rst;
  logic                   r_core_re;
  logic [AES_BLOCK_W-1:0] r_core_data;
  logic [AES_BLOCK_W-1:0] r_core_key;

  logic [NUM_REQ-1:0]     w_grant;
  logic [IDX_W-1:0]       w_grant_idx;
  logic                   w_accept;
  logic                   w_done_ev;
  logic                   w_wd_expired;
  logic                   w_wd_limit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req        (job.req_valid),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .grant_idx  (w_grant_idx)
  );

  // Accept only in IDLE; a reset cycle never accepts.
  assign w_accept     = (r_state == ST_IDLE) && (|job.req_valid) && !rst;
  assign w_wd_limit   = (r_wd_cnt == WD_W'(TIMEOUT));
  // Done wins over an expiring watchdog in the same cycle.
  assign w_done_ev    = (r_state == ST_BUSY) && core_done;
  assign w_wd_expired = (r_state == ST_BUSY) && !core_done && w_wd_limit;

  assign job.req_ready    = w_accept ? w_grant : '0;
  assign job.rsp_valid    = r_rsp_valid;
  assign job.rsp_data     = r_rsp_data;
  assign job.rsp_err      = r_rsp_err;
  assign core_rst         = r_core_rst;
  assign core_read_enable = r_core_re;
  assign core_data        = r_core_data;
  assign core_key         = r_core_key;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = ST_CLEAR;
      ST_CLEAR: w_next = ST_LOAD;
      ST_LOAD:  w_next = ST_BUSY;
      ST_BUSY:  if (w_done_ev || w_wd_expired) w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs, decoded from the upcoming state
  // so they line up with the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_wd_cnt     <= '0;
      r_rsp_valid  <= '0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      r_core_rst   <= 1'b1;
      r_core_re    <= 1'b0;
      r_core_data  <= '0;
      r_core_key   <= '0;
    end else begin
      r_core_rst  <= (w_next == ST_IDLE) || (w_next == ST_CLEAR);
      r_core_re   <= (w_next == ST_LOAD);
      r_rsp_valid <= '0;

      if (w_accept) begin
        r_core_data  <= job.req_data[w_grant_idx*AES_BLOCK_W +: AES_BLOCK_W];
        r_core_key   <= job.req_key[w_grant_idx*AES_BLOCK_W +: AES_BLOCK_W];
        r_last_grant <= w_grant_idx;
      end

      if (r_state == ST_LOAD) begin
        r_wd_cnt <= '0;
      end else if ((r_state == ST_BUSY) && !core_done && !w_wd_limit) begin
        r_wd_cnt <= r_wd_cnt + WD_W'(1);
      end

      if (w_done_ev) begin
        r_rsp_data  <= core_out_data;
        r_rsp_err   <= 1'b0;
        r_rsp_valid <= NUM_REQ'(1) << r_last_grant;
      end else if (w_wd_expired) begin
        r_rsp_data  <= '0;
        r_rsp_err   <= 1'b1;
        r_rsp_valid <= NUM_REQ'(1) << r_last_grant;
      end
    end
  end

endmodule
